dmem_requester: RTL
===================

DMEM_REQUESTER -- requirements
Module: dmem_requester

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  memory-stage request; accepted only in IDLE.
- icode  in  4  instruction code.
- valE  in  64  ALU result, used as an address.
- valA  in  64  register A value, used as data or address.
- valP  in  64  next-PC value, the call return address.
- instr_valid  in  1  decode-valid flag.
- imem_error  in  1  fetch address error.
- mem_req  out  1  memory request; held high until acknowledged.
- mem_we  out  1  1=write, 0=read; valid while mem_req is high.
- mem_addr  out  64  request address; stable while mem_req is high.
- mem_wdata  out  64  write data; stable while mem_req is high.
- mem_ack  in  1  responder completion; qualifies mem_rdata and mem_err.
- mem_rdata  in  64  read data.
- mem_err  in  1  responder access error.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- valM  out  64  read result; registered.
- stat  out  3  status: 1=AOK, 2=ADR, 3=INS, 4=HLT; registered.
REQ-003 The parameter SHALL be ADDR_MAX, default 8191, meaning the highest legal data address.
REQ-004 The parameter SHALL be TIMEOUT, default 16, meaning the number of REQ cycles without an ack that trigger an ADR error.

Function
REQ-005 The state machine SHALL have exactly three states: IDLE, REQ and DONE.
REQ-006 On start in IDLE, the block SHALL latch icode, valE, valA, valP, instr_valid and imem_error.
REQ-007 On start in IDLE, the block SHALL decode the latched operation as follows:
- icode 4: write, address valE, data valA.
- icode 5: read, address valE.
- icode 8: write, address valE, data valP.
- icode 9: read, address valA.
- icode 10: write, address valE, data valA.
- icode 11: read, address valA.
- any other icode: no memory access.
REQ-008 In IDLE with start high, the block SHALL go to DONE without asserting mem_req if any of these holds:
- the operation is not a memory access;
- instr_valid=0;
- imem_error=1;
- icode=0;
- the decoded address is greater than ADDR_MAX.
REQ-009 In every other case of start in IDLE, the block SHALL go to REQ.
REQ-010 In REQ, mem_req SHALL be high, and mem_we, mem_addr and mem_wdata SHALL hold their latched values.
REQ-011 In REQ, mem_wdata SHALL be 0 for reads.
REQ-012 When mem_ack=1 in REQ, the block SHALL go to DONE, and mem_req SHALL be low from the next cycle.
REQ-013 When mem_ack=1 in REQ on a read with mem_err=0, valM SHALL capture mem_rdata.
REQ-014 A 5-bit wait counter SHALL clear on entry to REQ and increment on each REQ cycle with mem_ack=0.
REQ-015 When the wait counter reaches TIMEOUT, the block SHALL drop mem_req and go to DONE with stat=2.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 stat SHALL be set on entry to DONE by the first matching rule:
1. icode=0 gives 4.
2. imem_error, an address greater than ADDR_MAX, mem_err with ack, or a timeout gives 2.
3. instr_valid=0 gives 3.
4. Otherwise stat is 1.
REQ-018 valM SHALL be set to 0 on entry to DONE for writes, non-memory operations and every error case.
REQ-019 The block SHALL ignore start while busy=1, with no latching and no effect.
REQ-020 Latency SHALL be as follows, with start in cycle N:
- no access: done in cycle N+1.
- access acknowledged in cycle N+k (k>=1): done in cycle N+k+1.
REQ-021 A mem_ack outside REQ SHALL be ignored.

Reset
REQ-022 Reset SHALL force the state to IDLE and clear the wait counter.
REQ-023 Reset SHALL force these output values:
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- busy=0, done=0;
- valM=0;
- stat=1.
REQ-024 Reset asserted in REQ SHALL drop mem_req at that edge, and no done SHALL follow.
REQ-025 Reset SHALL take priority over start and mem_ack in the same cycle.

Verification
REQ-026 The bench SHALL cover a write with immediate ack: icode=10, valE=0x100, valA=0xAB, start in cycle N -> mem_req=1, mem_we=1, addr 0x100, wdata 0xAB in N+1; ack in N+1 -> done in N+2, stat=1, valM=0.
REQ-027 The bench SHALL cover a read with wait states: icode=11, valA=0x40, ack in N+3 with rdata 0x1234 -> addr 0x40 held over N+1..N+3, done in N+4, valM=0x1234, stat=1.
REQ-028 The bench SHALL cover an out-of-range address: icode=5, valE=8192 -> mem_req never asserted, done in N+1, stat=2, valM=0.
REQ-029 The bench SHALL cover a timeout: icode=8 with ack held at 0 -> mem_req high for 16 cycles then low, done on the next cycle, stat=2.
REQ-030 The bench SHALL cover status priority: icode=0 with imem_error=1 -> done in N+1, stat=4; icode=6 with instr_valid=0 -> stat=3, no request.
REQ-031 The bench SHALL cover reset and busy behaviour: reset in the second REQ cycle -> mem_req=0 on the next cycle, no done; a start pulse while busy=1 -> ignored, latched address unchanged.

Source files
------------

// File: rtl/dmem_requester.sv
// -----------------------------------------------------------------------------
// dmem_requester
//
// Memory-stage data requester. A start pulse in IDLE captures one instruction's
// memory operands, decodes them into a single read or write transaction on a
// simple req/ack bus, waits for the responder (with a timeout), and reports a
// one-cycle done pulse together with the read result and a status code.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request from the memory stage, honoured only in IDLE
//   icode        instruction code selecting the operation
//   valE         ALU result (address for most operations)
//   valA         register A value (write data, or address for pop/ret)
//   valP         next PC (the return address pushed by call)
//   instr_valid  decode-valid flag
//   imem_error   fetch address error
//   mem_req      request strobe, held high until acknowledged or timed out
//   mem_we       1 = write, 0 = read, valid while mem_req is high
//   mem_addr     request address, stable while mem_req is high
//   mem_wdata    write data (zero for reads), stable while mem_req is high
//   mem_ack      responder completion, qualifies mem_rdata and mem_err
//   mem_rdata    read data
//   mem_err      responder access error
//   busy         high whenever the block is not in IDLE
//   done         one-cycle completion pulse
//   valM         registered read result (zero for writes and any error)
//   stat         registered status: 1=AOK, 2=ADR, 3=INS, 4=HLT
//
// Parameters
//   ADDR_MAX     highest legal data address
//   TIMEOUT      REQ cycles without an ack before the access is abandoned
// -----------------------------------------------------------------------------
module dmem_requester #(
  parameter logic [63:0] ADDR_MAX = 64'd8191,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic [2:0]  stat
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd3;
  localparam logic [2:0] STAT_HLT = 3'd4;

  // One extra bit on the comparison so a TIMEOUT of 32 still terminates.
  localparam logic [5:0] TIMEOUT_W = 6'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [4:0]  wait_cnt_reg;

  // Instruction context captured at start; used when the status is resolved
  // at the end of a bus transaction.
  logic [3:0]  icode_reg;
  logic        instr_valid_reg;
  logic        imem_error_reg;
  logic        is_read_reg;

  // Combinational decode of the live inputs, only consumed in IDLE.
  logic        dec_is_mem;
  logic        dec_we;
  logic [63:0] dec_addr;
  logic [63:0] dec_wdata;
  logic        dec_addr_bad;
  logic        dec_skip;

  logic [5:0]  wait_next;
  logic        timeout_hit;

  // First matching rule wins: halt, then address-class errors, then invalid
  // instruction, otherwise OK.
  function automatic logic [2:0] status_of(
    input logic [3:0] ic,
    input logic       fetch_err,
    input logic       addr_err,
    input logic       bus_err,
    input logic       iv
  );
    if (ic == 4'd0)
      return STAT_HLT;
    else if (fetch_err || addr_err || bus_err)
      return STAT_ADR;
    else if (!iv)
      return STAT_INS;
    else
      return STAT_AOK;
  endfunction

  always_comb begin
    dec_is_mem = 1'b1;
    dec_we     = 1'b0;
    dec_addr   = valE;
    dec_wdata  = 64'd0;
    case (icode)
      4'd4: begin            // rmmovq: M[valE] <- valA
        dec_we    = 1'b1;
        dec_wdata = valA;
      end
      4'd5: begin            // mrmovq: read M[valE]
        dec_we    = 1'b0;
      end
      4'd8: begin            // call: push return address
        dec_we    = 1'b1;
        dec_wdata = valP;
      end
      4'd9: begin            // ret: pop from old stack pointer
        dec_addr  = valA;
      end
      4'd10: begin           // pushq: M[valE] <- valA
        dec_we    = 1'b1;
        dec_wdata = valA;
      end
      4'd11: begin           // popq: pop from old stack pointer
        dec_addr  = valA;
      end
      default: begin
        dec_is_mem = 1'b0;
        dec_addr   = 64'd0;
      end
    endcase
  end

  // The range check only applies to operations that actually touch memory.
  assign dec_addr_bad = dec_is_mem && (dec_addr > ADDR_MAX);

  // Any of these short-circuits straight to DONE with no bus activity.
  assign dec_skip = !dec_is_mem || !instr_valid || imem_error ||
                    (icode == 4'd0) || dec_addr_bad;

  // The counter value after this cycle if no ack arrives; when that reaches
  // TIMEOUT the current cycle is the last REQ cycle.
  assign wait_next   = {1'b0, wait_cnt_reg} + 6'd1;
  assign timeout_hit = (wait_next >= TIMEOUT_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= 5'd0;
      icode_reg       <= 4'd0;
      instr_valid_reg <= 1'b0;
      imem_error_reg  <= 1'b0;
      is_read_reg     <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= 64'd0;
      mem_wdata       <= 64'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      valM            <= 64'd0;
      stat            <= STAT_AOK;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            icode_reg       <= icode;
            instr_valid_reg <= instr_valid;
            imem_error_reg  <= imem_error;
            is_read_reg     <= dec_is_mem && !dec_we;
            mem_we          <= dec_we;
            mem_addr        <= dec_addr;
            mem_wdata       <= dec_wdata;
            busy            <= 1'b1;
            if (dec_skip) begin
              state_reg <= DONE;
              done      <= 1'b1;
              valM      <= 64'd0;
              stat      <= status_of(icode, imem_error, dec_addr_bad,
                                     1'b0, instr_valid);
            end else begin
              state_reg    <= REQ;
              mem_req      <= 1'b1;
              wait_cnt_reg <= 5'd0;
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            state_reg <= DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            valM      <= (is_read_reg && !mem_err) ? mem_rdata : 64'd0;
            stat      <= status_of(icode_reg, imem_error_reg, 1'b0,
                                   mem_err, instr_valid_reg);
          end else begin
            wait_cnt_reg <= wait_next[4:0];
            if (timeout_hit) begin
              state_reg <= DONE;
              mem_req   <= 1'b0;
              done      <= 1'b1;
              valM      <= 64'd0;
              stat      <= STAT_ADR;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
